// File: rtl/visualitzador_8_bits_pkg.sv
// visualitzador_8_bits_pkg: shared FSM states, 7-segment/anode codes and BCD adjust helper
package visualitzador_8_bits_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [2:0][2:0] AN_SEL = {3'b011, 3'b101, 3'b110};
  function automatic logic [3:0] add3(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/visualitzador_8_bits_bcd_a_7seg.sv
// bcd_a_7seg: BCD digit plus blank flag to active-low 7-segment code {g,f,e,d,c,b,a}
module bcd_a_7seg
  import visualitzador_8_bits_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd];
endmodule

// File: rtl/visualitzador_8_bits.sv
// visualitzador_8_bits: serial double-dabble of valor into 3 BCD digits, multiplexed onto an/seg with busy flag
module visualitzador_8_bits
  import visualitzador_8_bits_pkg::*;
#(
  parameter int DIV   = 1000,
  parameter bit BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] valor,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  state_t state;
  logic [7:0] last_valor, cap, sh;
  logic [11:0] scr;
  logic [2:0] cnt;
  logic [3:0] d_h, d_t, d_u, dig;
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic blank_sel;
  logic [6:0] seg_c;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      last_valor <= '0;
      cap <= '0;
      sh <= '0;
      scr <= '0;
      cnt <= '0;
      d_h <= '0;
      d_t <= '0;
      d_u <= '0;
    end else begin
      case (state)
        IDLE: if (valor != last_valor) begin
          cap <= valor;
          sh <= valor;
          scr <= '0;
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {scr, sh} <= {add3(scr[11:8]), add3(scr[7:4]), add3(scr[3:0]), sh} << 1;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          {d_h, d_t, d_u} <= scr;
          last_valor <= cap;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_comb begin
    busy = state != IDLE;
    dig = idx == 2'd0 ? d_u : idx == 2'd1 ? d_t : d_h;
    blank_sel = BLANK && (idx == 2'd2 ? d_h == 4'd0 : idx == 2'd1 ? (d_h == 4'd0 && d_t == 4'd0) : 1'b0);
  end
  bcd_a_7seg u_seg (.bcd(dig), .blank(blank_sel), .seg(seg_c));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      presc <= '0;
      idx <= '0;
      seg <= SEG_DIGIT[0];
      an <= AN_SEL[0];
    end else begin
      presc <= presc == PW'(DIV - 1) ? '0 : presc + 1'b1;
      if (presc == PW'(DIV - 1)) idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
      seg <= seg_c;
      an <= AN_SEL[idx];
    end
endmodule

// File: tb/tb_visualitzador_8_bits.sv
// tb_visualitzador_8_bits: randomized and directed check of both blanking variants against a decimal display model
module tb_visualitzador_8_bits;
  localparam int DIV = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] valor = 8'd0;
  logic [6:0] seg1, seg0;
  logic [2:0] an1, an0;
  logic busy1, busy0;
  int n_cmp = 0, n_bad = 0;
  logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int m_cyc, m_last, m_shown, m_pend, m_left;
  logic [2:0] e_an;
  logic [6:0] e_seg1, e_seg0;
  logic e_busy;
  visualitzador_8_bits #(.DIV(DIV), .BLANK(1'b1)) u1 (.clk(clk), .rst(rst), .valor(valor), .seg(seg1), .an(an1), .busy(busy1));
  visualitzador_8_bits #(.DIV(DIV), .BLANK(1'b0)) u0 (.clk(clk), .rst(rst), .valor(valor), .seg(seg0), .an(an0), .busy(busy0));
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_of(input int v, input int i, input bit b);
    int h, t, u, d;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    d = i == 0 ? u : i == 1 ? t : h;
    if (b && ((i == 2 && h == 0) || (i == 1 && h == 0 && t == 0))) return 7'b1111111;
    return segt[d];
  endfunction
  function automatic logic [2:0] an_of(input int i);
    return i == 0 ? 3'b110 : i == 1 ? 3'b101 : 3'b011;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cyc = 0;
    m_last = 0;
    m_shown = 0;
    m_pend = 0;
    m_left = 0;
    e_an = 3'b110;
    e_seg1 = 7'b1000000;
    e_seg0 = 7'b1000000;
    e_busy = 1'b0;
  endtask
  task automatic model_step();
    int i;
    i = (m_cyc / DIV) % 3;
    e_an = an_of(i);
    e_seg1 = seg_of(m_shown, i, 1'b1);
    e_seg0 = seg_of(m_shown, i, 1'b0);
    m_cyc++;
    if (m_left == 0) begin
      if (int'(valor) != m_last) begin
        m_pend = int'(valor);
        m_left = 9;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_shown = m_pend;
        m_last = m_pend;
      end
    end
    e_busy = m_left > 0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    #1;
  endtask
  task automatic count_busy();
    int n;
    n = 0;
    repeat (12) begin
      tick();
      if (busy1) n++;
    end
    chk("busy_len", n, 9);
  endtask
  task automatic expect_digit(input logic [2:0] anv, input logic [6:0] s1, input logic [6:0] s0, input string nm);
    bit found;
    found = 0;
    for (int k = 0; k < 3 * DIV + 2 && !found; k++) begin
      tick();
      if (an1 == anv) found = 1;
    end
    chk({nm, "_found"}, 32'(found), 1);
    if (found) begin
      chk({nm, "_seg_b1"}, seg1, s1);
      chk({nm, "_seg_b0"}, seg0, s0);
    end
  endtask
  always @(negedge clk) begin
    chk("an_b1", an1, e_an);
    chk("an_b0", an0, e_an);
    chk("seg_b1", seg1, e_seg1);
    chk("seg_b0", seg0, e_seg0);
    chk("busy_b1", busy1, e_busy);
    chk("busy_b0", busy0, e_busy);
  end
  initial begin
    model_reset();
    valor = 8'd37;
    repeat (5) tick();
    chk("rst_an", an1, 3'b110);
    chk("rst_seg", seg1, 7'b1000000);
    chk("rst_busy", busy1, 0);
    rst = 1'b1;
    valor = 8'd255;
    count_busy();
    expect_digit(3'b110, 7'b0010010, 7'b0010010, "u255");
    expect_digit(3'b101, 7'b0010010, 7'b0010010, "t255");
    expect_digit(3'b011, 7'b0100100, 7'b0100100, "h255");
    valor = 8'd7;
    repeat (11) tick();
    expect_digit(3'b110, 7'b1111000, 7'b1111000, "u7");
    expect_digit(3'b101, 7'b1111111, 7'b1000000, "t7");
    expect_digit(3'b011, 7'b1111111, 7'b1000000, "h7");
    valor = 8'd255;
    repeat (11) tick();
    valor = 8'd0;
    count_busy();
    expect_digit(3'b110, 7'b1000000, 7'b1000000, "u0");
    expect_digit(3'b101, 7'b1111111, 7'b1000000, "t0");
    expect_digit(3'b011, 7'b1111111, 7'b1000000, "h0");
    valor = 8'd12;
    repeat (3) tick();
    valor = 8'd200;
    repeat (7) tick();
    chk("gap_busy", busy1, 0);
    tick();
    chk("rebusy", busy1, 1);
    repeat (10) tick();
    expect_digit(3'b011, 7'b0100100, 7'b0100100, "h200");
    expect_digit(3'b110, 7'b1000000, 7'b1000000, "u200");
    expect_digit(3'b101, 7'b1000000, 7'b1000000, "t200");
    valor = 8'd50;
    repeat (4) tick();
    rst = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", busy1, 0);
    chk("abort_an", an1, 3'b110);
    chk("abort_seg", seg1, 7'b1000000);
    repeat (2) tick();
    valor = 8'd99;
    rst = 1'b1;
    repeat (11) tick();
    expect_digit(3'b110, 7'b0010000, 7'b0010000, "u99");
    expect_digit(3'b101, 7'b0010000, 7'b0010000, "t99");
    expect_digit(3'b011, 7'b1111111, 7'b1000000, "h99");
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 12) valor = 8'($urandom);
      else if (r == 12) valor = 8'd0;
      else if (r == 13) valor = 8'd255;
      else if (r == 14) begin
        rst = 1'b0;
        model_reset();
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b1;
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
